// File: rtl/mul4_seq_sched_if.sv
// Handshake and data bundle between the operand source / result consumer and mul4_seq_sched.
interface mul4_seq_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a1;
  logic [15:0] a0;
  logic [15:0] b1;
  logic [15:0] b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y3;
  logic [15:0] y2;
  logic [15:0] y1;
  logic [15:0] y0;
  logic        busy;

  modport master (
    output in_valid, a1, a0, b1, b0, out_ready,
    input  in_ready, out_valid, y3, y2, y1, y0, busy
  );

  modport slave (
    input  in_valid, a1, a0, b1, b0, out_ready,
    output in_ready, out_valid, y3, y2, y1, y0, busy
  );
endinterface

// File: rtl/mul4_seq_sched.sv
// 32x32->64 multiply sequenced over one shared 16x16 multiplier in four partial-product steps.
// Optional MUL4_SEQ_ZERO_SKIP_EN: steps whose limb product is trivially zero are skipped.
module mul4_seq_sched (
  input  logic clk,
  input  logic rst_n,
  mul4_seq_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_step;
  logic [3:0]  r_run;
  logic [15:0] r_a1, r_a0, r_b1, r_b0;
  logic [63:0] r_acc;
  logic [63:0] r_y;

  logic [3:0]  w_run_in;
  logic [1:0]  w_step_first;
  logic [1:0]  w_step_next;
  logic        w_has_next;
  logic [15:0] w_op_a, w_op_b;
  logic [31:0] w_pp;
  logic [63:0] w_pp_sh;
  logic [63:0] w_acc_sum;
  logic        w_accept;

`ifdef MUL4_SEQ_ZERO_SKIP_EN
  // Bit k set means step k has a non-zero partial product and must be executed.
  assign w_run_in = { (bus.a1 != 16'd0) && (bus.b1 != 16'd0),
                      (bus.a0 != 16'd0) && (bus.b1 != 16'd0),
                      (bus.a1 != 16'd0) && (bus.b0 != 16'd0),
                      (bus.a0 != 16'd0) && (bus.b0 != 16'd0) };
`else
  assign w_run_in = 4'hF;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  always_comb begin
    w_step_first = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_run_in[k]) w_step_first = 2'(k);
    end
  end

  always_comb begin
    w_has_next  = 1'b0;
    w_step_next = r_step;
    for (int k = 3; k >= 0; k--) begin
      if (r_run[k] && (k > int'(r_step))) begin
        w_has_next  = 1'b1;
        w_step_next = 2'(k);
      end
    end
  end

  // Step encoding: bit0 selects the high A limb, bit1 the high B limb.
  assign w_op_a = r_step[0] ? r_a1 : r_a0;
  assign w_op_b = r_step[1] ? r_b1 : r_b0;
  assign w_pp   = {16'd0, w_op_a} * {16'd0, w_op_b};

  always_comb begin
    w_pp_sh = {32'd0, w_pp};
    case (r_step)
      2'd1, 2'd2: w_pp_sh = {16'd0, w_pp, 16'd0};
      2'd3:       w_pp_sh = {w_pp, 32'd0};
      default:    w_pp_sh = {32'd0, w_pp};
    endcase
  end

  assign w_acc_sum = r_acc + w_pp_sh;

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = (w_run_in == 4'd0) ? S_DONE : S_MUL;
      end
      S_MUL: begin
        bus.busy = 1'b1;
        if (!w_has_next) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= 2'd0;
      r_run   <= 4'd0;
      r_a1    <= 16'd0;
      r_a0    <= 16'd0;
      r_b1    <= 16'd0;
      r_b0    <= 16'd0;
      r_acc   <= 64'd0;
      r_y     <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a1  <= bus.a1;
        r_a0  <= bus.a0;
        r_b1  <= bus.b1;
        r_b0  <= bus.b0;
        r_acc <= 64'd0;
        r_run <= w_run_in;
        r_step <= w_step_first;
        if (w_run_in == 4'd0) r_y <= 64'd0;
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_sum;
        if (w_has_next) r_step <= w_step_next;
        else            r_y    <= w_acc_sum;
      end
    end
  end

  assign bus.y3 = r_y[63:48];
  assign bus.y2 = r_y[47:32];
  assign bus.y1 = r_y[31:16];
  assign bus.y0 = r_y[15:0];

endmodule

// File: tb/tb_mul4_seq_sched.sv
// Directed plus randomized bench for mul4_seq_sched against a plain-arithmetic product model.
module tb_mul4_seq_sched;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mul4_seq_sched_if bus ();

  mul4_seq_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] y_all();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  // Cycles from acceptance edge to out_valid (also the number of busy cycles).
  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL4_SEQ_ZERO_SKIP_EN
    int n;
    n = 0;
    if (a[15:0]  != 0 && b[15:0]  != 0) n++;
    if (a[31:16] != 0 && b[15:0]  != 0) n++;
    if (a[15:0]  != 0 && b[31:16] != 0) n++;
    if (a[31:16] != 0 && b[31:16] != 0) n++;
    return n;
`else
    return 4;
`endif
  endfunction

  // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input int bp, input bit scramble);
    logic [63:0] exp_y;
    logic [63:0] y_hold;
    int k;
    int busy_n;
    exp_y = {32'd0, a} * {32'd0, b};
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.a1 = a[31:16];
    bus.a0 = a[15:0];
    bus.b1 = b[31:16];
    bus.b0 = b[15:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = (bp == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    busy_n = 0;
    while (!bus.out_valid && k <= 20) begin
      if (bus.busy) busy_n++;
      check("in_ready_low_mul", bus.in_ready, 0);
      if (scramble) begin
        bus.a0 = 16'($urandom);
        bus.b0 = 16'($urandom);
      end
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(exp_latency(a, b)));
    check("busy_cycles", 64'(busy_n), 64'(exp_latency(a, b)));
    check("product", y_all(), exp_y);
    check("in_ready_done", bus.in_ready, 0);
    y_hold = y_all();
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_y_stable", y_all(), y_hold);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_in_ready", bus.in_ready, 1);
    check("post_out_valid", bus.out_valid, 0);
    check("post_y_hold", y_all(), exp_y);
  endtask

  initial begin
    int ready_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a1 = 16'd0;
    bus.a0 = 16'd0;
    bus.b1 = 16'd0;
    bus.b0 = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_y", y_all(), 64'd0);

    do_txn(32'h0001_0002, 32'h0003_0004, 0, 1'b0);
    do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0);
    check("max_product_const", y_all(), 64'hFFFF_FFFE_0000_0001);
    do_txn(32'h1234_ABCD, 32'h8765_4321, 0, 1'b1);

    // Asynchronous reset while step 2 is in flight.
    bus.a1 = 16'h0003;
    bus.a0 = 16'h0002;
    bus.b1 = 16'h0005;
    bus.b0 = 16'h0004;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_y", y_all(), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", bus.out_valid, 0);
    end
    do_txn(32'd5, 32'd7, 0, 1'b0);
    check("after_rst_y", y_all(), 64'h0000_0000_0000_0023);
    do_txn(32'd0, 32'h1234_5678, 1, 1'b0);

    // in_valid held high: only the single IDLE cycle in each 6-cycle window accepts.
    ready_cnt = 0;
    bus.a1 = 16'h0001;
    bus.a0 = 16'h0001;
    bus.b1 = 16'h0001;
    bus.b0 = 16'h0001;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready) ready_cnt++;
      check("excl_ready_valid", bus.in_ready & bus.out_valid, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("issue_interval", 64'(ready_cnt), 64'd2);
    check("stream_idle", bus.in_ready, 1);

    for (int t = 0; t < 8; t++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (t == 2) ra[15:0]  = 16'd0;
      if (t == 5) rb[31:16] = 16'd0;
      do_txn(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
